// File: rtl/mem_stage_dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs (package)
// Description : Shared definitions for the MIPS MEM stage: memory opcodes,
//               MEM-stage FSM state encoding, access-size encoding and an
//               alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Load opcodes (IR[31:26])
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  // Store opcodes
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  // MEM-stage wait-state FSM
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Access size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Byte accesses are always aligned; halves need bit 0 clear; words need
  // both low bits clear.
  function automatic logic is_aligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_WORD: is_aligned = (off == 2'b00);
      SZ_HALF: is_aligned = (off[0] == 1'b0);
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_dm_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : dm_byte_lane
// Description : Combinational byte-lane steering for the data memory.
//               Store path: merges byte/half/word write data into the old
//               word at the given offset (other bytes preserved).
//               Load path: extracts byte/half/word from the word at the given
//               offset and sign- or zero-extends it to 32 bits.
// Ports       : old_word  - current memory word (also the load source)
//               wdata     - store data (low bits used for byte/half)
//               size      - access size
//               offset    - byte offset within word (little-endian)
//               sign_ext  - sign-extend loaded byte/half when high
//               merged    - word to write back for a store
//               loaded    - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module dm_byte_lane
  import mips_defs::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  byte_lsb;
  logic [4:0]  half_lsb;

  assign byte_lsb = {offset, 3'b000};
  assign half_lsb = {offset[1], 4'b0000};

  assign sel_byte = old_word[byte_lsb +: 8];
  assign sel_half = old_word[half_lsb +: 16];

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[byte_lsb +: 8]  = wdata[7:0];
      SZ_HALF: merged[half_lsb +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    loaded = old_word;
    case (size)
      SZ_BYTE: loaded = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      SZ_HALF: loaded = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: loaded = old_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_dm.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_dm
// Description : MEM stage of the 5-stage MIPS pipeline. Decodes loads and
//               stores from the EX/MEM instruction, accesses an internal
//               word-organised little-endian data memory with optional wait
//               states, and registers the result into MEM/WB.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               IR_In/RD2_In/PC_In/ALU_In - EX/MEM register contents
//               Stall        - freeze upstream stages (combinational)
//               IR_W/PC_W/ALU_W/DM_W/AdE_W - MEM/WB register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_dm
  import mips_defs::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_In,
  input  logic [31:0] RD2_In,
  input  logic [31:0] PC_In,
  input  logic [31:0] ALU_In,
  output logic        Stall,
  output logic [31:0] IR_W,
  output logic [31:0] PC_W,
  output logic [31:0] ALU_W,
  output logic [31:0] DM_W,
  output logic        AdE_W
);

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic       HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [5:0] opcode;
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       sign_ext;
  size_t      size;
  logic       aligned;

  assign opcode = IR_In[31:26];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SZ_WORD;
    case (opcode)
      OP_LW:  begin is_load  = 1'b1; size = SZ_WORD; end
      OP_LB:  begin is_load  = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LH:  begin is_load  = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
      OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      default: ;
    endcase
  end

  assign is_mem  = is_load | is_store;
  assign aligned = is_aligned(size, ALU_In[1:0]);

  // Address bits above the memory depth are ignored, so addresses wrap.
  logic [ADDR_BITS-1:0] word_idx;
  logic                 unused_addr_hi;

  assign word_idx       = ALU_In[ADDR_BITS+1:2];
  assign unused_addr_hi = ^ALU_In[31:ADDR_BITS+2];

  // --------------------------------------------------------------------------
  // Memory array and byte-lane steering
  // --------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;
  logic [31:0] merged;
  logic [31:0] loaded;

  assign rd_word = mem[word_idx];

  dm_byte_lane u_lane (
    .old_word (rd_word),
    .wdata    (RD2_In),
    .size     (size),
    .offset   (ALU_In[1:0]),
    .sign_ext (sign_ext),
    .merged   (merged),
    .loaded   (loaded)
  );

  // --------------------------------------------------------------------------
  // Wait-state FSM
  // --------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       stall_int;
  logic       complete;
  logic       wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_int = 1'b0;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mem && HAS_WAIT) begin
          stall_int = 1'b1;
          state_nxt = S_BUSY;
          cnt_nxt   = CNT_LOAD;
        end else begin
          complete  = 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt != 4'd0) begin
          stall_int = 1'b1;
          cnt_nxt   = cnt - 4'd1;
        end else begin
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reset forces Stall low so the pipeline is not held frozen while clearing.
  assign Stall = stall_int & ~reset;

  // Misaligned stores are dropped; reset overrides any write (memory clear).
  assign wr_en = complete & is_store & aligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (wr_en) begin
      mem[word_idx] <= merged;
    end
  end

  // --------------------------------------------------------------------------
  // MEM/WB register: captures the instruction on completion, else a bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || !complete) begin
      IR_W  <= 32'd0;
      PC_W  <= 32'd0;
      ALU_W <= 32'd0;
      DM_W  <= 32'd0;
      AdE_W <= 1'b0;
    end else begin
      IR_W  <= IR_In;
      PC_W  <= PC_In;
      ALU_W <= ALU_In;
      DM_W  <= (is_load && aligned) ? loaded : 32'd0;
      AdE_W <= is_mem & ~aligned;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_dm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_dm
// Description : Directed self-checking bench for mem_stage_dm. Two instances
//               share the stimulus: one with no wait states, one with three.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_dm;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR, RD2, PC, ALU;

  logic        Stall0, AdE_W0;
  logic [31:0] IR_W0, PC_W0, ALU_W0, DM_W0;
  logic        Stall3, AdE_W3;
  logic [31:0] IR_W3, PC_W3, ALU_W3, DM_W3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_dm #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .IR_In(IR), .RD2_In(RD2), .PC_In(PC), .ALU_In(ALU),
    .Stall(Stall0), .IR_W(IR_W0), .PC_W(PC_W0), .ALU_W(ALU_W0), .DM_W(DM_W0), .AdE_W(AdE_W0)
  );

  mem_stage_dm #(.ADDR_BITS(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .IR_In(IR), .RD2_In(RD2), .PC_In(PC), .ALU_In(ALU),
    .Stall(Stall3), .IR_W(IR_W3), .PC_W(PC_W3), .ALU_W(ALU_W3), .DM_W(DM_W3), .AdE_W(AdE_W3)
  );

  function automatic logic [31:0] mk(input logic [5:0] op);
    mk = {op, 5'd1, 5'd2, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present new EX/MEM contents and let combinational outputs settle.
  task automatic drive(input logic [31:0] ir, input logic [31:0] rd2,
                       input logic [31:0] alu, input logic [31:0] pc);
    IR = ir; RD2 = rd2; ALU = alu; PC = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD_IR = 32'h00851020;

  initial begin
    reset = 1'b1;
    IR = '0; RD2 = '0; PC = '0; ALU = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir_w", IR_W0, 32'd0);
    chk("rst_dm_w", DM_W0, 32'd0);
    chk("rst_ade_w", {31'd0, AdE_W0}, 32'd0);
    chk("rst_stall0", {31'd0, Stall0}, 32'd0);
    chk("rst_stall3", {31'd0, Stall3}, 32'd0);
    reset = 1'b0;

    // ---------------- zero wait states ----------------
    drive(mk(OP_SW), 32'hDEADBEEF, 32'h10, 32'h400);
    chk("sw_stall0", {31'd0, Stall0}, 32'd0);
    tick();
    chk("sw_ir_w", IR_W0, mk(OP_SW));
    chk("sw_pc_w", PC_W0, 32'h400);
    chk("sw_dm_w", DM_W0, 32'd0);

    drive(mk(OP_LW), 32'd0, 32'h10, 32'h404);
    chk("lw_stall0", {31'd0, Stall0}, 32'd0);
    tick();
    chk("lw_dm_w", DM_W0, 32'hDEADBEEF);
    chk("lw_alu_w", ALU_W0, 32'h10);

    drive(mk(OP_SB), 32'hAAAAAA80, 32'h13, 32'h408);
    tick();
    drive(mk(OP_LB), 32'd0, 32'h13, 32'h40C);
    tick();
    chk("lb_dm_w", DM_W0, 32'hFFFFFF80);
    drive(mk(OP_LBU), 32'd0, 32'h13, 32'h410);
    tick();
    chk("lbu_dm_w", DM_W0, 32'h00000080);
    drive(mk(OP_LW), 32'd0, 32'h10, 32'h414);
    tick();
    chk("lw_after_sb", DM_W0, 32'h80ADBEEF);

    drive(mk(OP_SH), 32'hFFFF1234, 32'h22, 32'h418);
    tick();
    drive(mk(OP_LHU), 32'd0, 32'h22, 32'h41C);
    tick();
    chk("lhu_dm_w", DM_W0, 32'h00001234);
    drive(mk(OP_LH), 32'd0, 32'h22, 32'h420);
    tick();
    chk("lh_dm_w", DM_W0, 32'h00001234);
    drive(mk(OP_LW), 32'd0, 32'h20, 32'h424);
    tick();
    chk("lw_after_sh", DM_W0, 32'h12340000);

    drive(mk(OP_SH), 32'h0000BEEF, 32'h21, 32'h428);
    tick();
    chk("sh_mis_ade", {31'd0, AdE_W0}, 32'd1);
    chk("sh_mis_dm", DM_W0, 32'd0);
    drive(mk(OP_LW), 32'd0, 32'h20, 32'h42C);
    tick();
    chk("lw_after_missh", DM_W0, 32'h12340000);
    chk("lw_al_ade", {31'd0, AdE_W0}, 32'd0);

    drive(mk(OP_LW), 32'd0, 32'h12, 32'h430);
    tick();
    chk("lw_mis_ade", {31'd0, AdE_W0}, 32'd1);
    chk("lw_mis_dm", DM_W0, 32'd0);

    drive(mk(OP_LW), 32'd0, 32'h1010, 32'h434);
    tick();
    chk("lw_alias", DM_W0, 32'h80ADBEEF);

    drive(mk(OP_LH), 32'd0, 32'h12, 32'h438);
    tick();
    chk("lh_sign", DM_W0, 32'hFFFF80AD);

    // ---------------- three wait states ----------------
    drive(mk(OP_LW), 32'd0, 32'h10, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_gates_stall3", {31'd0, Stall3}, 32'd0);
    tick();
    reset = 1'b0;

    drive(ADD_IR, 32'd0, 32'h55, 32'h200);
    chk("add_stall0", {31'd0, Stall0}, 32'd0);
    chk("add_stall3", {31'd0, Stall3}, 32'd0);
    tick();
    chk("add_ir_w3", IR_W3, ADD_IR);
    chk("add_alu_w3", ALU_W3, 32'h55);
    chk("add_dm_w3", DM_W3, 32'd0);
    chk("add_alu_w0", ALU_W0, 32'h55);

    drive(mk(OP_SW), 32'h12345678, 32'h8, 32'h204);
    for (int k = 0; k < 3; k++) begin
      chk("sw3_stall", {31'd0, Stall3}, 32'd1);
      tick();
      chk("sw3_bubble", IR_W3, 32'd0);
    end
    chk("sw3_stall_end", {31'd0, Stall3}, 32'd0);
    tick();
    chk("sw3_ir_w", IR_W3, mk(OP_SW));

    drive(mk(OP_LW), 32'd0, 32'h8, 32'h208);
    for (int k = 0; k < 3; k++) begin
      chk("lw3_stall", {31'd0, Stall3}, 32'd1);
      tick();
      chk("lw3_bubble_ir", IR_W3, 32'd0);
      chk("lw3_bubble_dm", DM_W3, 32'd0);
    end
    chk("lw3_stall_end", {31'd0, Stall3}, 32'd0);
    tick();
    chk("lw3_ir_w", IR_W3, mk(OP_LW));
    chk("lw3_pc_w", PC_W3, 32'h208);
    chk("lw3_dm_w", DM_W3, 32'h12345678);

    // Reset in the second stall cycle aborts the store.
    drive(mk(OP_SW), 32'hCAFEF00D, 32'h40, 32'h20C);
    chk("abort_stall_a", {31'd0, Stall3}, 32'd1);
    tick();
    chk("abort_stall_b", {31'd0, Stall3}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_rst_stall", {31'd0, Stall3}, 32'd0);
    tick();
    reset = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0);
    chk("abort_idle_stall", {31'd0, Stall3}, 32'd0);
    chk("abort_ir_w", IR_W3, 32'd0);
    chk("abort_alu_w", ALU_W3, 32'd0);
    chk("abort_pc_w", PC_W3, 32'd0);

    drive(mk(OP_LW), 32'd0, 32'h40, 32'h210);
    for (int k = 0; k < 3; k++) begin
      chk("abort_lw_stall", {31'd0, Stall3}, 32'd1);
      tick();
    end
    chk("abort_lw_stall_end", {31'd0, Stall3}, 32'd0);
    tick();
    chk("abort_lw_ir_w", IR_W3, mk(OP_LW));
    chk("abort_lw_dm_w", DM_W3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs (instruction, store data, PC, ALU address) and decodes loads/stores. Performs byte/halfword/word access on an internal data memory, with a configurable wait-state stall. Registers results into the MEM/WB boundary for the WB stage.

Parameters:
ADDR_BITS, 10, word-address width; memory depth = 2**ADDR_BITS words.
WAIT_CYCLES, 0, extra stall cycles per load/store (0..15).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
IR_In  in  32  instruction from EX/MEM
RD2_In  in  32  store data from EX/MEM
PC_In  in  32  PC from EX/MEM
ALU_In  in  32  effective byte address / ALU result
Stall  out  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM while high
IR_W  out  32  MEM/WB instruction
PC_W  out  32  MEM/WB PC
ALU_W  out  32  MEM/WB ALU result
DM_W  out  32  MEM/WB load data, already extended
AdE_W  out  1  MEM/WB misaligned-address flag

Behaviour:
- Opcode is IR_In[31:26]. Loads: lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25. Stores: sw 0x2B, sb 0x28, sh 0x29. Every other opcode is a non-memory op.
- Word index = ALU_In[ADDR_BITS+1:2]. Higher address bits are ignored, so addresses wrap. Memory is little-endian: byte k of a word = bits [8k+7:8k].
- Alignment: lw/sw need ALU_In[1:0]==0. lh/lhu/sh need ALU_In[0]==0. A misaligned access suppresses the write, gives DM_W=0 and AdE_W=1. It keeps the same stall timing as an aligned access.
- Stores:
  - sw writes the full word.
  - sh writes RD2_In[15:0] to half ALU_In[1].
  - sb writes RD2_In[7:0] to byte ALU_In[1:0].
  - Other bytes of the word are preserved.
- Loads:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Read is combinational from the array and captured into DM_W at the completing edge.
  - Non-load ops give DM_W=0.
- FSM states: IDLE, BUSY; 4-bit counter cnt.
  - IDLE, memory op, WAIT_CYCLES>0: Stall=1, no access. Next state BUSY, cnt<=WAIT_CYCLES-1. MEM/WB captures a bubble.
  - IDLE, otherwise: Stall=0. Access completes at this edge and MEM/WB captures the instruction.
  - BUSY, cnt!=0: Stall=1, cnt<=cnt-1, MEM/WB captures a bubble.
  - BUSY, cnt==0: Stall=0. Access completes at this edge and MEM/WB captures the instruction. Next state IDLE.
  - Net effect: a memory op presented at cycle t completes at the end of cycle t+WAIT_CYCLES. Stall is high for exactly WAIT_CYCLES cycles. Non-memory ops never stall.
- Bubble = IR_W, PC_W, ALU_W, DM_W and AdE_W all 0.
- Upstream holds EX/MEM stable while Stall=1. The block does not re-latch its inputs.
- Reset:
  - All MEM/WB outputs go to 0 and the FSM goes to IDLE with cnt=0.
  - Every memory word is cleared to 0; a loop over the array is acceptable.
  - Stall=0 during reset.
  - Reset in BUSY aborts the access; no write occurs.
- Reset has priority over any store in the same cycle.
- Back-to-back stores then loads to the same word: the load sees the stored data. The store commits at an earlier edge than the load's capture edge.
- Initial values are all 0, matching reset.

Decomposition:
- Shared package (mips_defs) holds:
  - opcode constants: OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH;
  - FSM state encodings: S_IDLE=0, S_BUSY=1.
- One sub-module is natural: dm_byte_lane. It is combinational and does store-merge (old word, data, size, offset → new word) and load-extract/extend (word, size, offset, signed → 32-bit).
- The FSM, memory array and MEM/WB register live in mem_stage_dm.

Test Plan:
- WAIT_CYCLES=0. sw RD2=0xDEADBEEF at ALU=0x10, then lw ALU=0x10 → next-cycle DM_W=0xDEADBEEF. Stall never high.
- sb 0x80 to 0x13, then lb 0x13 → DM_W=0xFFFFFF80. Then lbu 0x13 → 0x00000080. Then lw 0x10 → 0x80ADBEEF (bytes 0-2 preserved).
- sh 0x1234 to 0x22, then lhu 0x22 → 0x00001234 and lw 0x20 → 0x12340000. Then sh to 0x21 → no write, AdE_W=1, DM_W=0, lw 0x20 unchanged.
- WAIT_CYCLES=3, lw presented at cycle t → Stall high t..t+2. MEM/WB is bubble (IR_W=0) on those edges. Valid IR_W/DM_W after edge ending t+3.
- WAIT_CYCLES=3, sw 0xCAFEF00D at 0x40 with reset asserted in the second stall cycle → FSM IDLE, Stall=0, outputs 0, and a later lw 0x40 returns 0.
- Non-memory op (add, opcode 0) with ALU=0x55 → ALU_W=0x55, DM_W=0, Stall=0 for any WAIT_CYCLES. Address 0x1010 with ADDR_BITS=10 aliases to word 4 (address 0x10).
